breakout_game_ctrl: RTL and testbench
=====================================

Name: breakout_game_ctrl

Overview:
Top-level game supervisor that sits directly downstream of the graphics/physics stage. It consumes that stage's hit/miss flags and the VGA pixel coordinates, and drives the gra_still freeze/restart control back into it. It keeps a 2-digit BCD score and the balls-remaining count for the text overlay, and sequences new game / play / new ball / game over. It also emits one-cycle sound-trigger pulses.

Parameters:
BALLS_INIT, 3, balls at start of game (1..3; balls counter is 2 bits)
TIMER_TICKS, 120, frame ticks to wait after a miss or at game over (2 s at 60 Hz); must fit 7 bits

Ports:
clk  input  1  system clock (pixel-tick domain shared with sync/graph stages)
reset  input  1  asynchronous, active-high reset
btn  input  5  raw debounced buttons; "press" = any bit set
pix_x  input  10  current pixel column from VGA sync
pix_y  input  10  current pixel row from VGA sync
hit  input  1  level from graph stage; may stay high for many clocks per collision
miss  input  1  level from graph stage; may stay high for many clocks
gra_still  output  1  1 = graph stage holds ball/paddle at initial position and clears bricks
game_state  output  2  0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER (text overlay select)
score_d1  output  4  BCD tens digit
score_d0  output  4  BCD units digit
balls  output  2  balls remaining, including the one in play
snd_hit  output  1  one-cycle pulse per counted hit
snd_miss  output  1  one-cycle pulse per counted miss

Behaviour:
- Clock and reset: reset reset, asynchronous, active-high; clock clk. All state is in flops on posedge clk / posedge reset.
- Reset values: state=NEWGAME, gra_still=1, game_state=0, score=00, balls=BALLS_INIT, timer=0, snd_hit=0, snd_miss=0, hit/miss edge registers=0.
- refr_tick = (pix_y==481 && pix_x==0). Combinational internal strobe, one clock per frame.
- Edge detection: hit_q/miss_q register the inputs every clock in all states. hit_rise = hit & ~hit_q; miss_rise = miss & ~miss_q. Only rising edges count; a level held across frames counts once.
- gra_still = (state != PLAY). It is decoded from the state register, so it changes on the same edge as state.
- Timer: 7-bit down-counter. Loaded with TIMER_TICKS on entry to NEWBALL or OVER. Decrements on refr_tick while nonzero. Saturates at 0; timer_up = (timer==0).
- FSM:
  - NEWGAME: on btn!=0, go to PLAY and clear score to 00 on that same edge. Score is otherwise preserved so the final score stays visible through OVER.
  - PLAY:
    - On hit_rise: score +1 in BCD. d0 9->0 carries into d1. 99 -> 00 wraps. snd_hit=1 for the next cycle.
    - On miss_rise: snd_miss=1 for the next cycle. If balls==1, set balls=0, load the timer, and go to OVER. Otherwise decrement balls, load the timer, and go to NEWBALL.
  - NEWBALL: go to PLAY only when timer_up && btn!=0. A button held during the countdown is accepted on the first clock after expiry.
  - OVER: when timer_up, go to NEWGAME and set balls=BALLS_INIT on that edge. Buttons are ignored.
- Simultaneous hit_rise and miss_rise in PLAY: both are processed in the same cycle. Score increments, both snd pulses fire, and the miss transition is taken.
- hit/miss edges outside PLAY: ignored. No score change, no pulses; edge registers still track the inputs.
- Latency:
  - Score, balls and snd_* update one clock after the rising edge of hit/miss is sampled.
  - gra_still rises one clock after a miss edge.
- Reset mid-operation: state returns to NEWGAME immediately and asynchronously, with all reset values above, regardless of timer or pending edges.

Test Plan:
- Reset, then btn=5'h01 for 1 clk -> game_state 0->1, gra_still=0, score=00, balls=3.
- In PLAY, hit held high 500 clocks spanning several refr_ticks -> score=01 exactly, snd_hit high exactly 1 cycle.
- In PLAY, 100 separate hit pulses -> score passes 09->10 and 99->00; final score=00, d1/d0 never exceed 9.
- balls=3, miss pulse -> balls=2, state NEWBALL, gra_still=1. btn held throughout -> PLAY resumes exactly 1 clk after the 120th refr_tick, not before.
- balls=1, miss -> balls=0, state OVER. After 120 refr_ticks -> NEWGAME with balls=3 and the old score still shown. Next btn -> score=00.
- hit and miss rise on the same clk with balls=2 -> score+1, both snd pulses, balls=1, NEWBALL. Reset asserted mid-countdown -> immediate NEWGAME reset values.

Source files
------------

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : breakout_game_ctrl
// Purpose  : Breakout game supervisor: sequencing, BCD score, balls, sound.
// Revision : 1.0 - initial release
// ============================================================================
module breakout_game_ctrl #(
    parameter int BALLS_INIT  = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] btn,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       hit,
    input  logic       miss,
    output logic       gra_still,
    output logic [1:0] game_state,
    output logic [3:0] score_d1,
    output logic [3:0] score_d0,
    output logic [1:0] balls,
    output logic       snd_hit,
    output logic       snd_miss
);

    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] BALLS_RST  = 2'(BALLS_INIT);
    localparam logic [6:0] TIMER_LOAD = 7'(TIMER_TICKS);

    state_t     state, state_nxt;
    logic [3:0] d1_nxt, d0_nxt;
    logic [1:0] balls_nxt;
    logic [6:0] timer, timer_nxt;
    logic       hit_q, miss_q;
    logic       hit_pulse, miss_pulse;

    logic refr_tick, hit_rise, miss_rise, press, timer_up;

    assign refr_tick  = (pix_y == 10'd481) && (pix_x == 10'd0);
    assign hit_rise   = hit & ~hit_q;
    assign miss_rise  = miss & ~miss_q;
    assign press      = |btn;
    assign timer_up   = (timer == 7'd0);
    assign gra_still  = (state != PLAY);
    assign game_state = state;

    always_comb begin
        state_nxt  = state;
        d1_nxt     = score_d1;
        d0_nxt     = score_d0;
        balls_nxt  = balls;
        timer_nxt  = timer;
        hit_pulse  = 1'b0;
        miss_pulse = 1'b0;
        if (refr_tick && !timer_up)
            timer_nxt = timer - 7'd1;
        case (state)
            NEWGAME: begin
                if (press) begin
                    state_nxt = PLAY;
                    d1_nxt    = 4'd0;
                    d0_nxt    = 4'd0;
                end
            end
            PLAY: begin
                if (hit_rise) begin
                    hit_pulse = 1'b1;
                    if (score_d0 == 4'd9) begin
                        d0_nxt = 4'd0;
                        d1_nxt = (score_d1 == 4'd9) ? 4'd0 : score_d1 + 4'd1;
                    end else begin
                        d0_nxt = score_d0 + 4'd1;
                    end
                end
                // A coincident miss still wins the state transition after the score update.
                if (miss_rise) begin
                    miss_pulse = 1'b1;
                    timer_nxt  = TIMER_LOAD;
                    balls_nxt  = balls - 2'd1;
                    state_nxt  = (balls == 2'd1) ? OVER : NEWBALL;
                end
            end
            NEWBALL: begin
                if (timer_up && press)
                    state_nxt = PLAY;
            end
            OVER: begin
                if (timer_up) begin
                    state_nxt = NEWGAME;
                    balls_nxt = BALLS_RST;
                end
            end
            default: state_nxt = NEWGAME;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= NEWGAME;
            score_d1 <= 4'd0;
            score_d0 <= 4'd0;
            balls    <= BALLS_RST;
            timer    <= 7'd0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            snd_hit  <= 1'b0;
            snd_miss <= 1'b0;
        end else begin
            state    <= state_nxt;
            score_d1 <= d1_nxt;
            score_d0 <= d0_nxt;
            balls    <= balls_nxt;
            timer    <= timer_nxt;
            hit_q    <= hit;
            miss_q   <= miss;
            snd_hit  <= hit_pulse;
            snd_miss <= miss_pulse;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_breakout_game_ctrl
// Purpose  : Scoreboard bench for breakout_game_ctrl with compressed frames.
// Revision : 1.0 - initial release
// ============================================================================
module tb_breakout_game_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btn = 5'd0;
    logic [9:0] pix_x = 10'd0;
    logic [9:0] pix_y = 10'd0;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       gra_still;
    logic [1:0] game_state;
    logic [3:0] score_d1, score_d0;
    logic [1:0] balls;
    logic       snd_hit, snd_miss;

    breakout_game_ctrl #(.BALLS_INIT(3), .TIMER_TICKS(120)) dut (
        .clk(clk), .reset(reset), .btn(btn), .pix_x(pix_x), .pix_y(pix_y),
        .hit(hit), .miss(miss), .gra_still(gra_still), .game_state(game_state),
        .score_d1(score_d1), .score_d0(score_d0), .balls(balls),
        .snd_hit(snd_hit), .snd_miss(snd_miss)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [14:0] val;
        int          ticks;
        int          since;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_count = 0;
    int   since = 0;
    int   phase = 0;

    // Frame of 8 clocks: one true refresh tick plus near-miss coordinates.
    always @(negedge clk) begin
        phase = (phase + 1) % 8;
        case (phase)
            0:       begin pix_y = 10'd481; pix_x = 10'd0; end
            1:       begin pix_y = 10'd481; pix_x = 10'd1; end
            2:       begin pix_y = 10'd480; pix_x = 10'd0; end
            default: begin pix_y = 10'd100; pix_x = 10'd5; end
        endcase
    end

    always @(posedge clk) begin
        if (pix_y == 10'd481 && pix_x == 10'd0) begin
            tick_count = tick_count + 1;
            since = 0;
        end else begin
            since = since + 1;
        end
    end

    task automatic expect_out(input string nm, input logic [1:0] gs, input int d1, input int d0,
                              input int bl, input bit sh, input bit sm,
                              input int tk = -1, input int sn = -1);
        exp_t e;
        e.name  = nm;
        e.val   = {gs, (gs != 2'd1), 4'(d1), 4'(d0), 2'(bl), sh, sm};
        e.ticks = tk;
        e.since = sn;
        sb.push_back(e);
    endtask

    logic [14:0] prev = 'x;
    logic [14:0] cur;

    always @(negedge clk) begin
        exp_t e;
        cur = {game_state, gra_still, score_d1, score_d0, balls, snd_hit, snd_miss};
        if (cur !== prev) begin
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_change: got %h, required no change from %h", cur, prev);
            end else begin
                e = sb.pop_front();
                if (cur !== e.val) begin
                    n_err = n_err + 1;
                    $display("FAIL %s: got gs/still/d1/d0/balls/sh/sm=%h, required %h", e.name, cur, e.val);
                end else if (e.ticks >= 0 && (tick_count != e.ticks || since != e.since)) begin
                    n_err = n_err + 1;
                    $display("FAIL %s_timing: got ticks=%0d since=%0d, required ticks=%0d since=%0d",
                             e.name, tick_count, since, e.ticks, e.since);
                end
            end
            prev = cur;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic zero_ticks_after_edge();
        @(posedge clk);
        #1;
        tick_count = 0;
    endtask

    initial begin
        expect_out("reset", 2'd0, 0, 0, 3, 0, 0);
        step(3);
        reset = 1'b0;
        step(2);

        expect_out("start_play", 2'd1, 0, 0, 3, 0, 0);
        btn = 5'h01;
        step(1);
        btn = 5'h00;
        step(3);

        // Long hit level: one count, one-cycle pulse.
        expect_out("hold_hit", 2'd1, 0, 1, 3, 1, 0);
        expect_out("hold_hit_end", 2'd1, 0, 1, 3, 0, 0);
        hit = 1'b1;
        step(500);
        hit = 1'b0;
        step(3);

        for (int k = 1; k <= 99; k++) begin
            int v;
            v = (1 + k) % 100;
            expect_out("hit_pulse", 2'd1, v / 10, v % 10, 3, 1, 0);
            expect_out("hit_pulse_end", 2'd1, v / 10, v % 10, 3, 0, 0);
            hit = 1'b1;
            step(1);
            hit = 1'b0;
            step(1);
        end
        step(3);

        // Miss with 3 balls, button held through the whole countdown.
        expect_out("miss3", 2'd2, 0, 0, 2, 0, 1);
        expect_out("miss3_end", 2'd2, 0, 0, 2, 0, 0);
        expect_out("newball_resume", 2'd1, 0, 0, 2, 0, 0, 120, 1);
        btn = 5'h10;
        miss = 1'b1;
        zero_ticks_after_edge();
        step(1);
        miss = 1'b0;
        step(1000);
        btn = 5'h00;
        step(3);

        expect_out("hit_miss_same", 2'd2, 0, 1, 1, 1, 1);
        expect_out("hit_miss_same_end", 2'd2, 0, 1, 1, 0, 0);
        hit = 1'b1;
        miss = 1'b1;
        step(1);
        hit = 1'b0;
        miss = 1'b0;
        step(1000);
        expect_out("newball_btn", 2'd1, 0, 1, 1, 0, 0);
        btn = 5'h04;
        step(1);
        btn = 5'h00;
        step(3);

        // Last ball: OVER ignores buttons and hits, then returns to NEWGAME.
        expect_out("miss_last", 2'd3, 0, 1, 0, 0, 1);
        expect_out("miss_last_end", 2'd3, 0, 1, 0, 0, 0);
        expect_out("over_expire", 2'd0, 0, 1, 3, 0, 0, 120, 1);
        miss = 1'b1;
        zero_ticks_after_edge();
        step(1);
        miss = 1'b0;
        step(10);
        btn = 5'h02;
        hit = 1'b1;
        step(3);
        btn = 5'h00;
        hit = 1'b0;
        step(1000);
        expect_out("new_game_clear", 2'd1, 0, 0, 3, 0, 0);
        btn = 5'h08;
        step(1);
        btn = 5'h00;
        step(3);

        expect_out("miss_again", 2'd2, 0, 0, 2, 0, 1);
        expect_out("miss_again_end", 2'd2, 0, 0, 2, 0, 0);
        miss = 1'b1;
        step(1);
        miss = 1'b0;
        step(300);
        // Short pulse between edges: only an asynchronous reset can see it.
        expect_out("async_reset", 2'd0, 0, 0, 3, 0, 0);
        @(posedge clk);
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        step(5);
        expect_out("post_reset_play", 2'd1, 0, 0, 3, 0, 0);
        btn = 5'h01;
        step(1);
        btn = 5'h00;
        step(10);

        n_cmp = n_cmp + 1;
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL pending_expectations: got %0d outstanding, required 0 (next: %s)",
                     sb.size(), sb[0].name);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
